// File: rtl/rca_pkg.sv
// Shared types and constants for the nibble-serial adder controller and its slice.
package rca_pkg;

  localparam int RCA_SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } rca_seq_state_t;

endpackage

// File: rtl/rca.sv
// 4-bit ripple-carry adder slice, purely combinational.
module rca
  import rca_pkg::*;
(
  input  logic [RCA_SLICE_W-1:0] a,
  input  logic [RCA_SLICE_W-1:0] b,
  input  logic                   cin,
  output logic [RCA_SLICE_W-1:0] s,
  output logic                   c4
);

  logic [RCA_SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < RCA_SLICE_W; gi++) begin : g_fa
    assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign c4 = c[RCA_SLICE_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Nibble-serial adder: one rca slice iterated over WIDTH/4 cycles, valid/ready on both sides.
// Optional subtract mode (in_sub port) is enabled by defining RCA_SEQ_CTRL_SUB_EN.
module rca_seq_ctrl
  import rca_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef RCA_SEQ_CTRL_SUB_EN
  input  logic             in_sub,
`endif
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / RCA_SLICE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if ((WIDTH % RCA_SLICE_W) != 0 || WIDTH < RCA_SLICE_W) begin : g_bad_width
    $fatal(1, "rca_seq_ctrl: WIDTH must be a non-zero multiple of 4");
  end

  rca_seq_state_t state_reg, state_next;

  logic [NIBBLES-1:0][RCA_SLICE_W-1:0] a_reg, b_reg, sum_reg;
  logic [IDX_W-1:0]                    idx_reg;
  logic                                carry_reg;
  logic [RCA_SLICE_W-1:0]              slice_s;
  logic                                slice_c4;
  logic                                accept;
  logic [WIDTH-1:0]                    b_load;
  logic                                carry_load;

  assign accept = in_valid && in_ready;

`ifdef RCA_SEQ_CTRL_SUB_EN
  // Subtraction is a + ~b + 1; the caller's carry-in is irrelevant then.
  assign b_load     = in_sub ? ~in_b : in_b;
  assign carry_load = in_sub ? 1'b1 : in_cin;
`else
  assign b_load     = in_b;
  assign carry_load = in_cin;
`endif

  rca u_rca (
    .a   (a_reg[idx_reg]),
    .b   (b_reg[idx_reg]),
    .cin (carry_reg),
    .s   (slice_s),
    .c4  (slice_c4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= in_a;
            b_reg     <= b_load;
            carry_reg <= carry_load;
            idx_reg   <= '0;
          end
        end
        BUSY: begin
          sum_reg[idx_reg] <= slice_s;
          carry_reg        <= slice_c4;
          // Counter parks on the last nibble so it never wraps.
          if (idx_reg != LAST_IDX) begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (idx_reg == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_sum  = sum_reg;
  assign out_cout = carry_reg;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed scoreboard bench for rca_seq_ctrl (WIDTH=32 main instance plus a WIDTH=4 instance).
module tb_rca_seq_ctrl;

  localparam int NIBBLES = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_cin, in_sub;
  logic [31:0] in_a, in_b, out_sum;
  logic        out_valid, out_ready, out_cout, busy;

  logic        w4_valid, w4_ready, w4_cin, w4_sub;
  logic [3:0]  w4_a, w4_b, w4_sum;
  logic        w4_ovalid, w4_oready, w4_cout, w4_busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  rca_seq_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef RCA_SEQ_CTRL_SUB_EN
    .in_sub    (in_sub),
`endif
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  rca_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w4_valid),
    .in_ready  (w4_ready),
    .in_a      (w4_a),
    .in_b      (w4_b),
`ifdef RCA_SEQ_CTRL_SUB_EN
    .in_sub    (w4_sub),
`endif
    .in_cin    (w4_cin),
    .out_valid (w4_ovalid),
    .out_ready (w4_oready),
    .out_sum   (w4_sum),
    .out_cout  (w4_cout),
    .busy      (w4_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [32:0] r;
    if (sub) r = {(a >= b), a - b};
    else     r = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    return r;
  endfunction

  // One full transaction on the main instance, with optional output backpressure.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input int hold);
    int n;
    logic [32:0] expv;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    check({tag, "_accept_wait"}, 64'(n < 50), 64'd1);
    exp_q.push_back(model(a, b, cin, sub));
    step();
    in_valid = 1'b0; in_a = ~a; in_b = a ^ b; in_cin = ~cin; in_sub = ~sub;
    check({tag, "_busy"}, {62'd0, busy, in_ready}, 64'b10);
    n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    check({tag, "_latency"}, 64'(n), 64'(NIBBLES));
    expv = exp_q[0];
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold"}, {29'd0, out_valid, in_ready, out_cout, out_sum},
            {29'd0, 1'b1, 1'b0, expv});
      step();
    end
    out_ready = 1'b1;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    if (exp_q.size() == 0) check({tag, "_queue"}, 64'd0, 64'd1);
    else check({tag, "_result"}, 64'({out_cout, out_sum}), 64'(exp_q.pop_front()));
    step();
    out_ready = 1'b0;
    check({tag, "_release"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    int n, seen, naccept, t1, t2;
    logic [32:0] expv;
    rst_n = 1'b0;
    in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; in_sub = 0; out_ready = 0;
    w4_valid = 0; w4_a = '0; w4_b = '0; w4_cin = 0; w4_sub = 0; w4_oready = 0;
    step(); step();
    check("reset_ctrl", {61'd0, in_ready, out_valid, busy}, 64'b100);
    check("reset_out", 64'({out_cout, out_sum}), 64'd0);
    rst_n = 1'b1;
    step();

    run_op("ovf", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
    run_op("bp", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 5);
    check("bp_value", 64'(model(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0)), 64'h0_2345_678A);

    // Back-to-back with in_valid held high and out_ready held high.
    in_a = 32'd1; in_b = 32'd2; in_cin = 0; in_sub = 0; in_valid = 1; out_ready = 1;
    naccept = 0; seen = 0; t1 = 0; t2 = 0;
    for (int c = 0; c < 30; c++) begin
      logic acc;
      acc = in_ready && in_valid;
      if (acc) exp_q.push_back(model(in_a, in_b, in_cin, 1'b0));
      if (out_valid) begin
        seen++;
        if (seen == 1) t1 = c; else t2 = c;
        if (exp_q.size() == 0) check("b2b_queue", 64'd0, 64'd1);
        else check("b2b_result", 64'({out_cout, out_sum}), 64'(exp_q.pop_front()));
      end
      step();
      if (acc) begin
        naccept++;
        if (naccept == 1) begin in_a = 32'd3; in_b = 32'd4; end
        else in_valid = 0;
      end
    end
    out_ready = 0;
    check("b2b_count", 64'(seen), 64'd2);
    check("b2b_spacing", 64'(t2 - t1), 64'(NIBBLES + 2));

    // Reset in the 4th BUSY cycle discards the op.
    in_a = 32'h100; in_b = 32'h200; in_cin = 0; in_valid = 1; out_ready = 1;
    step();
    in_valid = 0;
    step(); step(); step();
    check("midrst_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_state", {61'd0, in_ready, out_valid, busy}, 64'b100);
    check("midrst_out", 64'({out_cout, out_sum}), 64'd0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) seen++;
      step();
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    out_ready = 0;
    run_op("post_rst", 32'hA, 32'h5, 1'b0, 1'b0, 0);

    // WIDTH=4 instance: single-edge latency.
    w4_a = 4'h9; w4_b = 4'h8; w4_cin = 1; w4_valid = 1; w4_oready = 0;
    check("w4_ready", 64'(w4_ready), 64'd1);
    step();
    w4_valid = 0; w4_a = 4'h0; w4_b = 4'h0; w4_cin = 0;
    check("w4_busy", {62'd0, w4_busy, w4_ovalid}, 64'b10);
    n = 0;
    while (!w4_ovalid && n < 20) begin step(); n++; end
    check("w4_latency", 64'(n), 64'd1);
    check("w4_result", 64'({w4_cout, w4_sum}), 64'h12);
    w4_oready = 1;
    step();
    w4_oready = 0;
    check("w4_release", {62'd0, w4_ovalid, w4_ready}, 64'b01);

`ifdef RCA_SEQ_CTRL_SUB_EN
    run_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 0);
    check("sub_neg_value", 64'(model(32'd5, 32'd7, 1'b0, 1'b1)), 64'h0_FFFF_FFFE);
    run_op("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 2);
    check("sub_pos_value", 64'(model(32'd7, 32'd5, 1'b0, 1'b1)), 64'h1_0000_0002);
`endif

    run_op("mixed", 32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 1'b0, 1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
